// File: rtl/uart_pkg.sv
// Shared constants and types for the UART receive-side byte buffer.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int FIFO_DEPTH_LOG2 = 3;
    localparam int FIFO_DEPTH      = 1 << FIFO_DEPTH_LOG2;
    localparam int STAT_CNT_WIDTH  = 8;

    // One extra MSB distinguishes full from empty when the low bits match.
    typedef logic [FIFO_DEPTH_LOG2:0] ptr_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // NOTE: every path through an always_comb block must assign its outputs, so start from a default to avoid an inferred latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: drops errored frames, stores good bytes in a FWFT FIFO
// drained via valid/ready, and keeps saturating error/overflow statistics.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH_LOG2 = FIFO_DEPTH_LOG2,
    parameter int CNT_WIDTH  = STAT_CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  PAR_ERR,
    input  logic                  STP_ERR,
    input  logic                  RD_RDY,
    output logic                  RD_VLD,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  OVF_FLAG,
    output logic [CNT_WIDTH-1:0]  ERR_CNT,
    output logic [CNT_WIDTH-1:0]  DROP_CNT,
    input  logic                  CLR_STAT
);

    localparam int                  DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic                  ovf_q, ovf_d;

    logic empty, full;
    logic bad_frame, good_frame;
    logic push, pop, drop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);

    assign bad_frame  = Data_Valid & (PAR_ERR | STP_ERR);
    assign good_frame = Data_Valid & ~(PAR_ERR | STP_ERR);

    assign pop  = ~empty & RD_RDY;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push = good_frame & (~full | pop);
    assign drop = good_frame & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (CLR_STAT) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness comes from the pointers, so stale words are never visible.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= P_DATA;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (bad_frame),
        .clr (CLR_STAT),
        .cnt (ERR_CNT)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (drop),
        .clr (CLR_STAT),
        .cnt (DROP_CNT)
    );

    assign RD_VLD   = ~empty;
    assign RD_DATA  = empty ? '0 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign FULL     = full;
    assign LEVEL    = wr_ptr_q - rd_ptr_q;
    assign OVF_FLAG = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model updated on
// each clock edge, a negedge monitor comparing outputs, directed plus random stimulus.
module tb_uart_rx_fifo;

    localparam int DW      = 8;
    localparam int DL2     = 3;
    localparam int CW      = 8;
    localparam int DEPTH   = 1 << DL2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          Data_Valid = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          PAR_ERR = 1'b0;
    logic          STP_ERR = 1'b0;
    logic          RD_RDY = 1'b0;
    logic          CLR_STAT = 1'b0;
    logic          RD_VLD;
    logic [DW-1:0] RD_DATA;
    logic          FULL;
    logic [DL2:0]  LEVEL;
    logic          OVF_FLAG;
    logic [CW-1:0] ERR_CNT;
    logic [CW-1:0] DROP_CNT;

    uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2), .CNT_WIDTH(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .P_DATA     (P_DATA),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .RD_RDY     (RD_RDY),
        .RD_VLD     (RD_VLD),
        .RD_DATA    (RD_DATA),
        .FULL       (FULL),
        .LEVEL      (LEVEL),
        .OVF_FLAG   (OVF_FLAG),
        .ERR_CNT    (ERR_CNT),
        .DROP_CNT   (DROP_CNT),
        .CLR_STAT   (CLR_STAT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: the FIFO as a byte queue plus plain integer statistics.
    logic [DW-1:0] model_q[$];
    int  err_m  = 0;
    int  drop_m = 0;
    bit  ovf_m  = 0;
    bit  m_pop, m_good, m_bad;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            model_q.delete();
            err_m  = 0;
            drop_m = 0;
            ovf_m  = 0;
        end else begin
            m_pop  = RD_RDY && (model_q.size() > 0);
            m_bad  = Data_Valid && (PAR_ERR || STP_ERR);
            m_good = Data_Valid && !(PAR_ERR || STP_ERR);
            if (CLR_STAT) begin
                err_m  = 0;
                drop_m = 0;
                ovf_m  = 0;
            end else begin
                if (m_bad && err_m < CNT_MAX) err_m++;
                if (m_good && model_q.size() == DEPTH && !m_pop) begin
                    if (drop_m < CNT_MAX) drop_m++;
                    ovf_m = 1;
                end
            end
            if (m_pop) void'(model_q.pop_front());
            if (m_good && model_q.size() < DEPTH) model_q.push_back(P_DATA);
        end
    end

    // Monitor: on a pop the head byte leaving the DUT must match the model's head.
    always @(negedge CLK) begin
        if (RST) begin
            if (RD_VLD && RD_RDY) begin
                if (model_q.size() > 0) check("pop_data", RD_DATA, model_q[0]);
                else check("pop_on_model_empty", RD_VLD, 0);
            end
            check("rd_vld", RD_VLD, model_q.size() > 0);
            check("rd_data_head", RD_DATA, (model_q.size() > 0) ? model_q[0] : '0);
            check("level", LEVEL, model_q.size());
            check("full", FULL, model_q.size() == DEPTH);
            check("ovf_flag", OVF_FLAG, ovf_m);
            check("err_cnt", ERR_CNT, err_m);
            check("drop_cnt", DROP_CNT, drop_m);
        end
    end

    // Apply one cycle of inputs; returns #1 after the edge that sampled them.
    task automatic drive(input bit dv, input logic [DW-1:0] d, input bit par,
                         input bit stp, input bit rdy, input bit clr);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_ERR    = par;
        STP_ERR    = stp;
        RD_RDY     = rdy;
        CLR_STAT   = clr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input bit rdy, input int n);
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, rdy, 0);
    endtask

    initial begin
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_level", LEVEL, 0);
        check("reset_rd_vld", RD_VLD, 0);
        check("reset_rd_data", RD_DATA, 0);
        RST = 1'b1;

        // Three good frames held, then drained.
        drive(1, 8'h41, 0, 0, 0, 0);
        drive(1, 8'h42, 0, 0, 0, 0);
        drive(1, 8'h43, 0, 0, 0, 0);
        check("t1_level", LEVEL, 3);
        check("t1_rd_vld", RD_VLD, 1);
        check("t1_head", RD_DATA, 8'h41);
        idle(1, 3);
        check("t1_empty_vld", RD_VLD, 0);
        check("t1_empty_data", RD_DATA, 0);

        // Errored frames are discarded and counted.
        drive(1, 8'h55, 1, 0, 0, 0);
        drive(1, 8'h66, 0, 1, 0, 0);
        drive(1, 8'h77, 0, 0, 0, 0);
        check("t2_err_cnt", ERR_CNT, 2);
        check("t2_level", LEVEL, 1);
        check("t2_head", RD_DATA, 8'h77);
        idle(1, 1);

        // Fill, overflow, then push-while-full with a concurrent pop.
        for (int i = 0; i < DEPTH; i++) drive(1, DW'(i), 0, 0, 0, 0);
        drive(1, 8'hAA, 0, 0, 0, 0);
        check("t3_full", FULL, 1);
        check("t3_ovf", OVF_FLAG, 1);
        check("t3_drop_cnt", DROP_CNT, 1);
        check("t3_head", RD_DATA, 8'h00);
        drive(1, 8'hBB, 0, 0, 1, 0);
        check("t4_level", LEVEL, DEPTH);
        check("t4_drop_cnt", DROP_CNT, 1);
        check("t4_head", RD_DATA, 8'h01);
        idle(1, DEPTH - 1);
        check("t4_last", RD_DATA, 8'hBB);
        idle(1, 1);
        check("t4_drained", RD_VLD, 0);

        // Error counter saturation and clear-beats-increment.
        for (int i = 0; i < 300; i++) drive(1, DW'($urandom), 1, i[0], 0, 0);
        check("t5_err_sat", ERR_CNT, CNT_MAX);
        drive(1, 8'h12, 0, 1, 0, 1);
        check("t5_err_clr", ERR_CNT, 0);
        check("t5_drop_clr", DROP_CNT, 0);
        check("t5_ovf_clr", OVF_FLAG, 0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) drive(1, DW'(8'h90 + i), 0, 0, 0, 0);
        check("t6_level5", LEVEL, 5);
        #2;
        RST = 1'b0;
        #1;
        check("t6_async_level", LEVEL, 0);
        check("t6_async_vld", RD_VLD, 0);
        check("t6_async_data", RD_DATA, 0);
        check("t6_async_full", FULL, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        check("t6_post_level", LEVEL, 0);
        drive(1, 8'h3C, 0, 0, 0, 0);
        check("t6_first", RD_DATA, 8'h3C);
        idle(1, 1);

        // Randomized traffic with varying drain pressure.
        for (int i = 0; i < 1500; i++) begin
            int phase;
            phase = (i / 150) % 3;
            drive($urandom_range(0, 3) != 0,
                  DW'($urandom),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  (phase == 0) ? ($urandom_range(0, 5) == 0) :
                  (phase == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 5) != 0),
                  $urandom_range(0, 99) == 0);
        end
        idle(1, DEPTH + 2);
        check("final_empty", RD_VLD, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's one-cycle Data_Valid pulse and discards any byte flagged with a parity or stop error. Accepted bytes are stored in a first-word-fall-through FIFO and drained by the host/register-file side through a valid/ready interface. The block also keeps saturating error and overflow statistics.

Parameters:
DATA_WIDTH, 8, width of received byte and FIFO entry
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)
CNT_WIDTH, 8, width of each statistics counter

Ports:
CLK  input  1  single system clock, rising edge
RST  input  1  asynchronous, active-low reset
Data_Valid  input  1  one-cycle pulse from receiver, frame complete
P_DATA  input  DATA_WIDTH  received byte, valid while Data_Valid=1
PAR_ERR  input  1  parity error for the current frame, sampled with Data_Valid
STP_ERR  input  1  stop-bit error for the current frame, sampled with Data_Valid
RD_RDY  input  1  consumer ready; pops the head entry when RD_VLD=1
RD_VLD  output  1  FIFO non-empty, RD_DATA valid
RD_DATA  output  DATA_WIDTH  head entry (FWFT); 0 when empty
FULL  output  1  FIFO holds 2^DEPTH_LOG2 entries
LEVEL  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
OVF_FLAG  output  1  sticky: a good byte was dropped because the FIFO was full
ERR_CNT  output  CNT_WIDTH  saturating count of frames dropped for PAR_ERR or STP_ERR
DROP_CNT  output  CNT_WIDTH  saturating count of good frames dropped on overflow
CLR_STAT  input  1  synchronous clear of ERR_CNT, DROP_CNT, OVF_FLAG

Behaviour:
- Reset (RST=0, async): read and write pointers = 0, LEVEL = 0, RD_VLD = 0, RD_DATA = 0, FULL = 0, OVF_FLAG = 0, ERR_CNT = 0, DROP_CNT = 0. Storage array is not reset. A reset mid-stream discards all contents.
- Pointers are DEPTH_LOG2+1 bits with natural wrap.
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal, MSBs differ).
  - LEVEL = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
- Frame classification, evaluated only in a cycle where Data_Valid=1:
  - bad = PAR_ERR | STP_ERR.
  - bad: byte is not written; ERR_CNT increments.
  - good: pushed if space is available, otherwise dropped.
- pop = RD_VLD & RD_RDY.
- push = good & (!FULL | pop).
  - A simultaneous pop on a full FIFO frees a slot, so the byte is accepted and LEVEL stays unchanged.
- Good frame with FULL=1 and no pop:
  - byte dropped, contents unchanged;
  - OVF_FLAG set;
  - DROP_CNT increments.
- Push and pop in the same cycle with the FIFO non-empty and non-full: both happen and LEVEL is unchanged.
- Pop on empty is impossible, because RD_VLD=0 when empty.
- Latency:
  - A byte pushed at rising edge N makes RD_VLD=1 and RD_DATA valid after edge N, i.e. one cycle after the Data_Valid pulse. No bypass path exists.
  - RD_DATA updates to the next entry after the popping edge.
- RD_DATA is the combinational read of mem[rd_ptr], gated to 0 when empty.
- FULL and RD_VLD are derived from the registered pointers only (no combinational path from inputs).
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- CLR_STAT=1 zeroes ERR_CNT, DROP_CNT and OVF_FLAG at the next edge. If an increment event occurs in the same cycle, the clear wins and the event is lost.
- CLR_STAT does not affect FIFO contents.
- No state machine is needed beyond the pointer and counter state. All storage is edge-triggered on CLK.

Decomposition:
- Shared package uart_pkg:
  - DATA_WIDTH default;
  - FIFO depth constant;
  - counter width constant;
  - ptr_t typedef (DEPTH_LOG2+1 bits).
- One sub-module, sat_counter: parameter CNT_WIDTH; ports CLK, RST, inc, clr, cnt.
  - clr has priority over inc; cnt holds at the maximum value.
  - Instantiated twice, for ERR_CNT and DROP_CNT.

Test Plan:
- Reset then three good frames 0x41, 0x42, 0x43 with RD_RDY=0 -> LEVEL=3, RD_VLD=1, RD_DATA=0x41. Then RD_RDY=1 for 3 cycles -> read 0x41, 0x42, 0x43, then RD_VLD=0, RD_DATA=0.
- Frame 0x55 with PAR_ERR=1, then 0x66 with STP_ERR=1, then 0x77 good -> only 0x77 stored, ERR_CNT=2, LEVEL=1.
- Fill 8 good frames 0x00..0x07, then 0xAA with RD_RDY=0 -> FULL=1, 0xAA dropped, OVF_FLAG=1, DROP_CNT=1. Drain -> reads 0x00..0x07 in order.
- With FULL=1, drive 0xBB concurrent with RD_RDY=1 -> 0x00 popped, 0xBB accepted, LEVEL stays 8, DROP_CNT unchanged; last entry drained is 0xBB.
- Drive 300 bad frames -> ERR_CNT saturates at 255. Assert CLR_STAT concurrently with one more bad frame -> ERR_CNT=0.
- Assert RST low mid-stream with LEVEL=5 -> outputs immediately zero with no clock edge. After release, LEVEL=0, RD_VLD=0, and the next good frame 0x3C is read first.
